fifo_pack_reader: RTL and testbench
===================================

# fifo_pack_reader

Drain stage placed directly downstream of the team's synchronous FIFO. It pops narrow DATA_WIDTH entries through the FIFO's read port and accounts for the FIFO's one-cycle registered read latency. It packs PACK_RATIO consecutive entries into one OUT-wide word and presents that word on a valid/ready output port. It sustains one FIFO pop per cycle and never reads an empty FIFO.

## Interface
- DATA_WIDTH, 2, width of one FIFO entry
- PACK_RATIO, 4, entries per output word (integer ≥ 2); OUT = DATA_WIDTH*PACK_RATIO
- clk  input  1  sole clock, rising edge
- rst  input  1  reset; one clock, synchronous, active-high
- fifo_empty  input  1  FIFO empty flag
- fifo_rd  output  1  FIFO read strobe; combinational from registered state and fifo_empty
- fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted fifo_rd
- out_valid  output  1  out_data holds a packed word
- out_ready  input  1  consumer accepts the word when high together with out_valid
- out_data  output  OUT  packed word; first-popped entry in bits [DATA_WIDTH-1:0]
- words_out  output  16  count of transferred output words, wraps modulo 2^16

## Operation
- State:
  - fill: 0..PACK_RATIO lanes held in the accumulator. fill = PACK_RATIO means a complete word is held.
  - in_flight: 1 bit, a pop whose data arrives this cycle.
  - Output register: out_valid and out_data.
- out_free = !out_valid || out_ready.
- fifo_rd = !fifo_empty && ((fill + in_flight < PACK_RATIO) || out_free). It is never asserted while fifo_empty=1.
- in_flight is loaded from fifo_rd each cycle.
- When in_flight=1, fifo_data is written into lane fill, and fill increments.
- Word completion (fill reaches PACK_RATIO this cycle):
  - If out_free, load the output register directly: lanes 0..PACK_RATIO-2 come from the accumulator and the top lane from fifo_data (bypass). out_valid=1 and fill is set to 0.
  - Otherwise, hold the word with fill=PACK_RATIO.
- A held word (fill=PACK_RATIO, in_flight=0) moves to the output register in the first cycle out_free=1. fill becomes 0 in that cycle.
- The fifo_rd rule guarantees that in_flight=1 never coincides with a held word that cannot move. Returning data is never dropped.
- Output transfer occurs when out_valid && out_ready. If no new word loads that cycle, out_valid clears. words_out increments by 1 on each transfer.
- out_data and out_valid stay stable while out_valid && !out_ready.
- Unused accumulator lanes are don't-care. out_data is only meaningful while out_valid=1.

## Timing
- Reset values:
  - fifo_rd=0 during the reset cycle
  - out_valid=0
  - out_data=0
  - words_out=0
  - fill=0
  - in_flight=0
- Reset mid-operation: any pop issued in the cycle before reset has its data discarded. That entry is lost, because the FIFO pointer has already advanced. Partial accumulator contents are discarded.
- Latency: fifo_rd high in cycle t, data sampled in t+1. With out_free, out_valid rises in cycle L+2, where L is the cycle of the word's last fifo_rd.
- Throughput: with fifo_empty=0 and out_ready=1 continuously, fifo_rd stays 1 every cycle. out_valid pulses for one cycle every PACK_RATIO cycles.
- Backpressure: with out_ready=0, at most PACK_RATIO further entries are popped after out_valid rises. fifo_rd then stays 0 until out_ready=1.
- fifo_empty rising while in_flight=1 has no effect on capturing that data.
- If out_ready=1 in the same cycle a held or bypassed word completes, the old word transfers and the new word loads in that edge. out_valid stays 1.
- fill wraps from PACK_RATIO to 0 only on a load into the output register. It never wraps in any other way.

## Test plan
- Reset, then preload 4 entries 0,1,2,3 (DATA_WIDTH=2, PACK_RATIO=4) with out_ready=1 -> fifo_rd high for 4 consecutive cycles; one word out_data=8'hE4 with out_valid for 1 cycle; words_out=1.
- Continuous stream of 64 entries, out_ready=1 -> fifo_rd never drops; 16 words with out_valid spaced exactly 4 cycles; words_out=16; data in order.
- out_ready=0 with 12 entries available -> exactly 8 pops (one word in the output register, one held). fifo_rd=0 afterwards and out_data stable. Raising out_ready -> the next 3 words drain in order with no loss.
- FIFO runs empty after 2 entries, 2 more arrive 10 cycles later -> fifo_rd=0 while fifo_empty=1; a single word completes correctly with the lanes in arrival order.
- Assert rst in the cycle after a fifo_rd with fill=2 -> next cycle out_valid=0, fill=0, words_out=0; the returned data is ignored; the next word starts at lane 0.
- Set words_out to 16'hFFFF via 65535 transfers (or force), then one more transfer -> words_out=0.

Source files
------------

// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: drains a FIFO with one-cycle registered read data and packs
// PACK_RATIO consecutive entries into one word on a valid/ready output port.
module fifo_pack_reader #(
    parameter int DATA_WIDTH = 2,
    parameter int PACK_RATIO = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               fifo_empty,
    output logic                               fifo_rd,
    input  logic [DATA_WIDTH-1:0]              fifo_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0]   out_data,
    output logic [15:0]                        words_out
);
    localparam int OUT_W  = DATA_WIDTH * PACK_RATIO;
    localparam int FILL_W = $clog2(PACK_RATIO + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PACK_RATIO);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PACK_RATIO - 1);
    localparam logic [FILL_W:0]   OCC_FULL  = (FILL_W + 1)'(PACK_RATIO);

    logic [FILL_W-1:0] fill_q, fill_d;
    logic              in_flight_q;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [15:0]       words_q, words_d;
    logic              out_free;
    logic              xfer;
    logic              load;
    logic [FILL_W:0]   occupancy;

    assign out_free  = !out_valid_q || out_ready;
    assign xfer      = out_valid_q && out_ready;
    assign occupancy = {1'b0, fill_q} + {{FILL_W{1'b0}}, in_flight_q};

    // Popping past a full word is only allowed when the output register can
    // take a word this cycle, so returning data always has a lane to land in.
    assign fifo_rd = !rst && !fifo_empty && ((occupancy < OCC_FULL) || out_free);

    always_comb begin
        fill_d     = fill_q;
        acc_d      = acc_q;
        load       = 1'b0;
        out_data_d = out_data_q;
        if (fill_q == FILL_FULL) begin
            if (out_free) begin
                load       = 1'b1;
                out_data_d = acc_q;
                fill_d     = '0;
            end
        end else if (in_flight_q) begin
            for (int i = 0; i < PACK_RATIO; i++) begin
                if (fill_q == FILL_W'(i)) begin
                    acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
                end
            end
            if (fill_q == FILL_LAST) begin
                if (out_free) begin
                    load       = 1'b1;
                    out_data_d = {fifo_data, acc_q[OUT_W-DATA_WIDTH-1:0]};
                    fill_d     = '0;
                end else begin
                    fill_d = FILL_FULL;
                end
            end else begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
        out_valid_d = load ? 1'b1 : (xfer ? 1'b0 : out_valid_q);
        words_d     = words_q + {15'd0, xfer};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q      <= '0;
            in_flight_q <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            words_q     <= '0;
        end else begin
            fill_q      <= fill_d;
            in_flight_q <= fifo_rd;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            words_q     <= words_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign words_out = words_q;
endmodule

// File: tb/tb_fifo_pack_reader.sv
// Bench for fifo_pack_reader: FIFO model with registered read data, a packing
// scoreboard built from popped entries, and directed plus random scenarios.
module tb_fifo_pack_reader;
    localparam int DW = 2;
    localparam int PR = 4;
    localparam int OW = DW * PR;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd;
    logic [DW-1:0] fifo_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] out_data;
    logic [15:0]   words_out;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] lanes_q[$];
    logic [OW-1:0] exp_q[$];
    logic [15:0]   exp_words = '0;
    logic          pend = 1'b0;
    logic [DW-1:0] pend_data = '0;
    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data = '0;
    int            cyc = 0;
    int            rd_log[$];
    int            val_log[$];
    logic [OW-1:0] val_data[$];
    logic          s_rd = 1'b0;
    logic          s_v = 1'b0;

    fifo_pack_reader #(.DATA_WIDTH(DW), .PACK_RATIO(PR)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .fifo_data(fifo_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .words_out(words_out)
    );

    always #5 clk = ~clk;

    // One clock: sample at the falling edge, advance FIFO and reference at the rising edge.
    task automatic tick();
        logic          rd, v, r;
        logic [OW-1:0] d, w;
        fifo_empty = (fifo_q.size() == 0);
        @(negedge clk);
        rd = fifo_rd; v = out_valid; r = out_ready; d = out_data;
        if (fifo_empty) begin
            checks++;
            if (rd !== 1'b0) begin errors++; $display("FAIL rd_while_empty cyc=%0d fifo_rd=%b want 0", cyc, rd); end
        end
        if (prev_stall) begin
            checks++;
            if (v !== 1'b1 || d !== prev_data) begin
                errors++; $display("FAIL stall_stable cyc=%0d valid=%b data=%h want 1 %h", cyc, v, d, prev_data);
            end
        end
        if (v === 1'b1 && r && !rst) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL word_order cyc=%0d got %h want none", cyc, d);
            end else begin
                w = exp_q.pop_front();
                if (d !== w) begin errors++; $display("FAIL word_order cyc=%0d got %h want %h", cyc, d, w); end
            end
            exp_words = exp_words + 16'd1;
        end
        prev_stall = (v === 1'b1) && !r && !rst;
        prev_data  = d;
        s_rd = rd; s_v = v;
        if (rd === 1'b1) rd_log.push_back(cyc);
        if (v === 1'b1) begin val_log.push_back(cyc); val_data.push_back(d); end
        @(posedge clk);
        if (rst) begin
            lanes_q.delete(); exp_q.delete(); exp_words = '0;
        end else if (pend) begin
            lanes_q.push_back(pend_data);
            if (lanes_q.size() == PR) begin
                w = '0;
                for (int i = 0; i < PR; i++) w[i*DW +: DW] = lanes_q[i];
                exp_q.push_back(w);
                lanes_q.delete();
            end
        end
        pend = (rd === 1'b1) && !rst && (fifo_q.size() > 0);
        if (rd === 1'b1 && fifo_q.size() > 0) pend_data = fifo_q.pop_front();
        #1;
        fifo_data = pend ? pend_data : DW'($urandom);
        checks++;
        if (words_out !== exp_words) begin
            errors++; $display("FAIL words_out cyc=%0d got %h want %h", cyc, words_out, exp_words);
        end
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_logs();
        rd_log.delete(); val_log.delete(); val_data.delete();
    endtask

    task automatic do_reset();
        fifo_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b0;
        ticks(2);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || words_out !== 16'd0) begin
            errors++; $display("FAIL reset_values valid=%b data=%h words=%h want 0 0 0", out_valid, out_data, words_out);
        end
        fifo_q.push_back(2'd1);
        fifo_empty = 1'b0;
        #1;
        checks++;
        if (fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_rd fifo_rd=%b want 0", fifo_rd); end
        do_reset();
    endtask

    task automatic test_single_word();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'(i));
        ticks(10);
        checks++;
        if (rd_log.size() != 4 || rd_log[3] - rd_log[0] != 3) begin
            errors++; $display("FAIL single_rd_run pops=%0d want 4 consecutive", rd_log.size());
        end
        checks++;
        if (val_log.size() != 1 || val_data[0] !== 8'hE4) begin
            errors++; $display("FAIL single_word valid_cycles=%0d data=%h want 1 e4", val_log.size(), val_data.size() ? val_data[0] : '0);
        end else begin
            checks++;
            if (val_log[0] != rd_log[3] + 2) begin
                errors++; $display("FAIL single_latency valid_at=%0d want %0d", val_log[0], rd_log[3] + 2);
            end
        end
        checks++;
        if (words_out !== 16'd1) begin errors++; $display("FAIL single_count words=%0d want 1", words_out); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) fifo_q.push_back(DW'($urandom));
        ticks(72);
        checks++;
        if (rd_log.size() != 64 || rd_log[63] - rd_log[0] != 63) begin
            errors++; $display("FAIL stream_rd pops=%0d want 64 back to back", rd_log.size());
        end
        checks++;
        if (val_log.size() != 16) begin
            errors++; $display("FAIL stream_words valid_cycles=%0d want 16", val_log.size());
        end else begin
            for (int i = 1; i < 16; i++) begin
                checks++;
                if (val_log[i] - val_log[i-1] != PR) begin
                    errors++; $display("FAIL stream_spacing word=%0d gap=%0d want %0d", i, val_log[i] - val_log[i-1], PR);
                end
            end
        end
        checks++;
        if (words_out !== 16'd16 || exp_q.size() != 0) begin
            errors++; $display("FAIL stream_count words=%0d pending=%0d want 16 0", words_out, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) fifo_q.push_back(DW'($urandom));
        ticks(20);
        checks++;
        if (rd_log.size() != 8) begin errors++; $display("FAIL bp_pops got %0d want 8", rd_log.size()); end
        checks++;
        if (s_rd !== 1'b0 || s_v !== 1'b1) begin
            errors++; $display("FAIL bp_hold fifo_rd=%b valid=%b want 0 1", s_rd, s_v);
        end
        out_ready = 1'b1;
        ticks(20);
        checks++;
        if (words_out !== 16'd3 || exp_q.size() != 0 || fifo_q.size() != 0) begin
            errors++; $display("FAIL bp_drain words=%0d pending=%0d left=%0d want 3 0 0", words_out, exp_q.size(), fifo_q.size());
        end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] e[4];
        logic [OW-1:0] w;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) e[i] = DW'($urandom);
        fifo_q.push_back(e[0]); fifo_q.push_back(e[1]);
        ticks(12);
        checks++;
        if (rd_log.size() != 2 || val_log.size() != 0) begin
            errors++; $display("FAIL uf_partial pops=%0d words=%0d want 2 0", rd_log.size(), val_log.size());
        end
        fifo_q.push_back(e[2]); fifo_q.push_back(e[3]);
        ticks(8);
        w = {e[3], e[2], e[1], e[0]};
        checks++;
        if (val_log.size() != 1 || val_data[0] !== w) begin
            errors++; $display("FAIL uf_word cycles=%0d data=%h want 1 %h", val_log.size(), val_data.size() ? val_data[0] : '0, w);
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] e[7];
        logic [OW-1:0] w;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) e[i] = DW'($urandom);
        for (int i = 0; i < 4; i++) fifo_q.push_back(e[i]);
        ticks(3);
        rst = 1'b1;
        tick();
        checks++;
        if (s_rd !== 1'b0) begin errors++; $display("FAIL mid_reset_rd fifo_rd=%b want 0", s_rd); end
        rst = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || words_out !== 16'd0) begin
            errors++; $display("FAIL mid_reset_state valid=%b words=%0d want 0 0", out_valid, words_out);
        end
        clear_logs();
        for (int i = 4; i < 7; i++) fifo_q.push_back(e[i]);
        ticks(10);
        w = {e[6], e[5], e[4], e[3]};
        checks++;
        if (val_log.size() != 1 || val_data[0] !== w) begin
            errors++; $display("FAIL mid_reset_word cycles=%0d data=%h want 1 %h", val_log.size(), val_data.size() ? val_data[0] : '0, w);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        force dut.words_q = 16'hFFFF;
        #1;
        release dut.words_q;
        exp_words = 16'hFFFF;
        checks++;
        if (words_out !== 16'hFFFF) begin errors++; $display("FAIL wrap_preset words=%h want ffff", words_out); end
        for (int i = 0; i < 4; i++) fifo_q.push_back(DW'($urandom));
        ticks(8);
        checks++;
        if (words_out !== 16'h0000 || val_log.size() != 1) begin
            errors++; $display("FAIL wrap words=%h cycles=%0d want 0000 1", words_out, val_log.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) fifo_q.push_back(DW'($urandom));
            end
            tick();
        end
        out_ready = 1'b1;
        ticks(40);
        checks++;
        if (exp_q.size() != 0 || fifo_q.size() != 0 || lanes_q.size() >= PR) begin
            errors++; $display("FAIL random_drain pending=%0d left=%0d lanes=%0d want 0 0 <%0d", exp_q.size(), fifo_q.size(), lanes_q.size(), PR);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_backpressure();
        test_underflow();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
